// File: rtl/alu_pkg.sv
// Shared widths and opcode encoding for the AND/ADD/ADC execute-stage slice.
package alu_pkg;

    localparam int WIDTH = 20;
    localparam int HALF  = WIDTH / 2;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_ADD  = 2'b01,
        OP_ADC  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Clears everything above the half-word when mode selects half-word.
    function automatic logic [WIDTH-1:0] mask_active(input logic [WIDTH-1:0] value,
                                                     input logic            full);
        logic [WIDTH-1:0] masked;
        masked = full ? value : {{(WIDTH-HALF){1'b0}}, value[HALF-1:0]};
        return masked;
    endfunction

endpackage

// File: rtl/alu_add_core.sv
// Combinational adder with carry-in; produces the active-width sum and the
// carry out of the active width (bit WIDTH in full-word, bit HALF in half-word).
module alu_add_core
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] a_active;
    logic [WIDTH-1:0] b_active;
    logic [WIDTH:0]   raw_sum;

    // Upper operand bits are zeroed in half-word mode, so bit HALF of the
    // raw sum is exactly the half-word carry.
    assign a_active = mask_active(a, mode);
    assign b_active = mask_active(b, mode);
    assign raw_sum  = {1'b0, a_active} + {1'b0, b_active} + {{WIDTH{1'b0}}, cin};

    assign sum  = mask_active(raw_sum[WIDTH-1:0], mode);
    assign cout = mode ? raw_sum[WIDTH] : raw_sum[HALF];

endmodule

// File: rtl/alu_and_add_slice.sv
// Registered 20-bit AND/ADD/ADC slice with full/half-word modes, producing
// result, zero and carry flags one cycle after an accepted request.
module alu_and_add_slice
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c,
    output logic             zero,
    output logic             carry
);

    op_e              op_dec;
    logic             accept;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic [WIDTH-1:0] and_result;

    logic [WIDTH-1:0] c_reg,         c_next;
    logic             zero_reg,      zero_next;
    logic             carry_reg,     carry_next;
    logic             out_valid_reg;

    assign op_dec = op_e'(op);
    assign accept = in_valid && (op_dec != OP_RSVD);

    // ADC chains off the registered flag, so a back-to-back ADC sees the
    // carry produced by the immediately preceding add.
    assign add_cin = (op_dec == OP_ADC) ? carry_reg : 1'b0;

    alu_add_core u_add_core (
        .a    (a),
        .b    (b),
        .cin  (add_cin),
        .mode (mode),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign and_result = mask_active(a & b, mode);

    always_comb begin
        c_next     = c_reg;
        zero_next  = zero_reg;
        carry_next = carry_reg;
        if (accept) begin
            unique case (op_dec)
                OP_AND: begin
                    c_next = and_result;
                end
                OP_ADD, OP_ADC: begin
                    c_next     = add_sum;
                    carry_next = add_cout;
                end
                default: begin
                    c_next = c_reg;
                end
            endcase
            // Inactive upper bits are already zero, so a whole-word test
            // covers both modes.
            zero_next = (c_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg         <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            c_reg         <= c_next;
            zero_reg      <= zero_next;
            carry_reg     <= carry_next;
            out_valid_reg <= accept;
        end
    end

    assign c         = c_reg;
    assign zero      = zero_reg;
    assign carry     = carry_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_alu_and_add_slice.sv
// Directed and reference-model checks for alu_and_add_slice.
module tb_alu_and_add_slice;

    localparam int W = 20;
    localparam int H = 10;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [1:0]    op;
    logic          mode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic [W-1:0]  c;
    logic          zero;
    logic          carry;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] m_c;
    logic         m_zero;
    logic         m_carry;

    alu_and_add_slice dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c         (c),
        .zero      (zero),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
    endtask

    // Drive one request after a falling edge; return after the next falling
    // edge so outputs of that request are stable.
    task automatic step(input logic v, input logic [1:0] o, input logic md,
                        input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = v;
        op       = o;
        mode     = md;
        a        = av;
        b        = bv;
        @(negedge clk);
        $display("txn v=%0b op=%0d mode=%0b a=%05h b=%05h -> ov=%0b c=%05h z=%0b cy=%0b",
                 v, o, md, av, bv, out_valid, c, zero, carry);
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [W-1:0] ce,
                              input logic ze, input logic cye);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".c"},         32'(c),         32'(ce));
        check({tag, ".zero"},      32'(zero),      32'(ze));
        check({tag, ".carry"},     32'(carry),     32'(cye));
    endtask

    // Independent reference for one request applied to the m_* state.
    task automatic model_step(input logic v, input logic [1:0] o, input logic md,
                              input logic [W-1:0] av, input logic [W-1:0] bv,
                              output logic ov);
        int unsigned wa, wb, s, lim;
        ov = v && (o != 2'b11);
        if (!ov) return;
        wa  = md ? int'(av) : int'(av) % (1 << H);
        wb  = md ? int'(bv) : int'(bv) % (1 << H);
        lim = md ? (1 << W) : (1 << H);
        if (o == 2'b00) begin
            m_c = W'(wa & wb);
        end else begin
            s       = wa + wb + ((o == 2'b10 && m_carry) ? 1 : 0);
            m_carry = (s >= lim);
            m_c     = W'(s % lim);
        end
        m_zero = (m_c == 0);
    endtask

    initial begin
        logic ov_e;
        rst_n = 1'b0;
        in_valid = 1'b0; op = 2'b00; mode = 1'b1; a = '0; b = '0;
        repeat (2) @(negedge clk);
        expect_out("reset", 1'b0, 20'h00000, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 2'b01, 1'b1, 20'h12345, 20'h11111);
        expect_out("idle", 1'b0, 20'h00000, 1'b0, 1'b0);

        step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'h00001);
        expect_out("add_full_wrap", 1'b1, 20'h00000, 1'b1, 1'b1);
        step(1'b1, 2'b10, 1'b1, 20'h00001, 20'h00002);
        expect_out("adc_full", 1'b1, 20'h00004, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 20'hAB3FF, 20'h00001);
        expect_out("add_half", 1'b1, 20'h00000, 1'b1, 1'b1);
        step(1'b1, 2'b00, 1'b1, 20'hF0F0F, 20'h0FFF0);
        expect_out("and_full", 1'b1, 20'h00F00, 1'b0, 1'b1);
        step(1'b1, 2'b00, 1'b0, 20'hFFC00, 20'hFFFFF);
        expect_out("and_half", 1'b1, 20'h00000, 1'b1, 1'b1);
        step(1'b1, 2'b11, 1'b1, 20'h00005, 20'h00005);
        expect_out("reserved", 1'b0, 20'h00000, 1'b1, 1'b1);
        step(1'b0, 2'b00, 1'b1, 20'hFFFFF, 20'hFFFFF);
        expect_out("no_request", 1'b0, 20'h00000, 1'b1, 1'b1);

        step(1'b1, 2'b01, 1'b1, 20'h80000, 20'h80000);
        expect_out("b2b_add", 1'b1, 20'h00000, 1'b1, 1'b1);
        step(1'b1, 2'b10, 1'b1, 20'h00010, 20'h00020);
        expect_out("b2b_adc", 1'b1, 20'h00031, 1'b0, 1'b0);
        step(1'b1, 2'b00, 1'b1, 20'h12345, 20'h0F0F0);
        expect_out("b2b_and", 1'b1, 20'h02040, 1'b0, 1'b0);

        step(1'b1, 2'b01, 1'b0, 20'h553FF, 20'hAA3FF);
        expect_out("add_half_carry", 1'b1, 20'h003FE, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 20'hFFC01, 20'h00000);
        expect_out("adc_half", 1'b1, 20'h00002, 1'b0, 1'b0);

        // Build nonzero state, then assert reset mid-cycle with a request pending.
        step(1'b1, 2'b01, 1'b1, 20'hFFFFF, 20'h00005);
        expect_out("pre_reset", 1'b1, 20'h00004, 1'b0, 1'b1);
        in_valid = 1'b1; op = 2'b01; mode = 1'b1; a = 20'hFFFFF; b = 20'hFFFFF;
        #2 rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 20'h00000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        expect_out("post_reset_idle", 1'b0, 20'h00000, 1'b0, 1'b0);

        m_c = '0; m_zero = 1'b0; m_carry = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic          rv;
            logic [1:0]    ro;
            logic          rm;
            logic [W-1:0]  ra, rb;
            rv = ($urandom_range(0, 7) != 0);
            ro = 2'($urandom_range(0, 3));
            rm = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 16 == 0) begin
                ra = (i % 32 == 0) ? 20'hFFFFF : ra;
                rb = (i % 32 == 0) ? 20'h00001 : rb;
            end
            model_step(rv, ro, rm, ra, rb, ov_e);
            step(rv, ro, rm, ra, rb);
            expect_out("random", ov_e, m_c, m_zero, m_carry);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
